banco_registros_rtc: RTL

Parametrised register bank that stores the RTC clock, date and timer fields for the VGA display path. It sits between the PicoBlaze data bus, the local counters and the VGA text generator. Each channel is loaded from the PicoBlaze bus through one addressed write port, holds its value, or tracks its counter. The block also provides BCD-correct 12/24-hour translation and the timer-alarm state machine.

---
 rtl/banco_registros_rtc.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/banco_registros_rtc.sv
// RTC register bank for the VGA text path: addressed PicoBlaze writes, per-channel
// hold/count tracking, BCD 12/24-hour translation and the timer alarm FSM with blink.
module banco_registros_rtc #(
  parameter int N_CANALES = 9,
  parameter int ANCHO     = 8,
  parameter int IDX_HORA  = 2,
  parameter int IDX_TSEG  = 6,
  parameter int IDX_TMIN  = 7,
  parameter int IDX_THORA = 8,
  parameter int BLINK_DIV = 25_000_000,
  parameter int AW        = $clog2(N_CANALES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       formato_hora,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [ANCHO-1:0]           data_in,
  input  logic [N_CANALES-1:0]       hold,
  input  logic [N_CANALES*ANCHO-1:0] count_in,
  input  logic                       timer_config,
  input  logic                       alarma_off,
  output logic [N_CANALES*ANCHO-1:0] out_dato,
  output logic [1:0]                 out_banderas,
  output logic                       am_pm,
  output logic                       mostrar_count,
  output logic                       alarma,
  output logic                       blink
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {ESPERA, CONF, RUN, ALARMA} estado_t;

  logic [ANCHO-1:0] canal_q [N_CANALES];
  logic [ANCHO-1:0] canal_d [N_CANALES];
  logic [1:0]       banderas_q, banderas_d;
  estado_t          estado_q, estado_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             blink_q, blink_d;

  logic             t_cero;
  logic [7:0]       hora, hora_out;
  logic [6:0]       hora_dec, pm_dec;
  logic             hora_valida;

  // Channel and flag next-state: write beats hold, hold beats counter tracking.
  always_comb begin
    for (int i = 0; i < N_CANALES; i++) begin
      if (wr_en && wr_addr == AW'(i))  canal_d[i] = data_in;
      else if (hold[i])                canal_d[i] = canal_q[i];
      else                             canal_d[i] = count_in[i*ANCHO +: ANCHO];
    end
    banderas_d = banderas_q;
    if (wr_en && wr_addr == AW'(N_CANALES)) banderas_d = data_in[1:0];
  end

  assign t_cero = (canal_q[IDX_THORA] == '0) && (canal_q[IDX_TMIN] == '0) &&
                  (canal_q[IDX_TSEG] == '0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      ESPERA: if (timer_config) estado_d = CONF;
      CONF:   if (!timer_config) estado_d = t_cero ? ESPERA : RUN;
      RUN: begin
        if (timer_config) estado_d = CONF;
        else if (t_cero)  estado_d = ALARMA;
      end
      ALARMA: if (alarma_off) estado_d = ESPERA;
      default: estado_d = ESPERA;
    endcase

    cnt_d   = '0;
    blink_d = 1'b0;
    if (estado_q == ALARMA && estado_d == ALARMA) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        blink_d = blink_q;
      end
    end
  end

  // NOTE: the channel array is a bank of flops, not a RAM, so it is cleared on reset like any state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CANALES; i++) canal_q[i] <= '0;
      banderas_q <= '0;
      estado_q   <= ESPERA;
      cnt_q      <= '0;
      blink_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_CANALES; i++) canal_q[i] <= canal_d[i];
      banderas_q <= banderas_d;
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
    end
  end

  // 12-hour translation works in decimal so 13..23 map back to correct BCD 1..11.
  assign hora        = canal_q[IDX_HORA][7:0];
  assign hora_valida = (hora[7:4] <= 4'd9) && (hora[3:0] <= 4'd9) && (hora <= 8'h23);
  assign hora_dec    = 7'(hora[7:4]) * 7'd10 + 7'(hora[3:0]);
  assign pm_dec      = hora_dec - 7'd12;

  always_comb begin
    hora_out = hora;
    am_pm    = 1'b0;
    if (formato_hora) begin
      if (!hora_valida) begin
        hora_out = 8'h00;
      end else if (hora == 8'h00) begin
        hora_out = 8'h12;
      end else if (hora <= 8'h11) begin
        hora_out = hora;
      end else if (hora == 8'h12) begin
        hora_out = 8'h12;
        am_pm    = 1'b1;
      end else begin
        hora_out = (pm_dec >= 7'd10) ? {4'd1, 4'(pm_dec - 7'd10)} : {4'd0, pm_dec[3:0]};
        am_pm    = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CANALES; i++) begin
      out_dato[i*ANCHO +: ANCHO] = (i == IDX_HORA) ? ANCHO'(hora_out) : canal_q[i];
    end
  end

  assign out_banderas  = banderas_q;
  assign mostrar_count = (estado_q != RUN);
  assign alarma        = (estado_q == ALARMA);
  assign blink         = blink_q;

endmodule
